// File: rtl/control_sequencer.sv
// Five-state instruction sequencer for a 2-operand memory-to-memory ISA
// (ADD/CMP/MOV/BEQ) driving an external async-read RAM and an external ALU.
module control_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [15:0] mem_rdata,
  output logic [6:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [1:0]  alu_op,
  input  logic [15:0] alu_in_out,
  input  logic        alu_in_z,
  output logic [6:0]  pc,
  output logic        z_flag,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    RD_SRC = 3'd2,
    RD_DST = 3'd3,
    EXEC   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_CMP = 2'b01,
    OP_MOV = 2'b10,
    OP_BEQ = 2'b11
  } opcode_t;

  state_t      r_state;
  logic [6:0]  r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_ra;
  logic [15:0] r_rb;
  logic        r_z;

  opcode_t     w_op;
  logic [6:0]  w_src;
  logic [6:0]  w_dst;

  assign w_op  = opcode_t'(r_ir[15:14]);
  assign w_src = r_ir[13:7];
  assign w_dst = r_ir[6:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_z     <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (en) begin
            r_ir    <= mem_rdata;
            r_pc    <= r_pc + 7'd1;
            r_state <= DECODE;
          end
        end
        DECODE: begin
          if (w_op == OP_BEQ) begin
            if (r_z) r_pc <= w_dst;
            r_state <= FETCH;
          end else begin
            r_state <= RD_SRC;
          end
        end
        RD_SRC: begin
          r_rb    <= mem_rdata;
          r_state <= (w_op == OP_MOV) ? EXEC : RD_DST;
        end
        RD_DST: begin
          r_ra    <= mem_rdata;
          r_state <= EXEC;
        end
        EXEC: begin
          // MOV is a plain copy and must not disturb the flag a later BEQ tests
          if (w_op != OP_MOV) r_z <= alu_in_z;
          r_state <= FETCH;
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  // Decoded from the state register so reset removes the write strobe at once
  always_comb begin
    mem_addr = r_pc;
    alu_op   = 2'd0;
    mem_we   = 1'b0;
    case (r_state)
      RD_SRC: mem_addr = w_src;
      RD_DST: mem_addr = w_dst;
      EXEC: begin
        mem_addr = w_dst;
        case (w_op)
          OP_CMP:  alu_op = 2'd1;
          OP_MOV:  alu_op = 2'd2;
          default: alu_op = 2'd0;
        endcase
        mem_we = (w_op == OP_ADD) || (w_op == OP_MOV);
      end
      default: ;
    endcase
  end

  assign mem_wdata = alu_in_out;
  assign alu_a     = r_ra;
  assign alu_b     = r_rb;
  assign pc        = r_pc;
  assign z_flag    = r_z;
  assign state     = r_state;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: RAM and ALU models around the sequencer, with an
// instruction-level reference model predicting memory, PC, Z and timing.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] mem_rdata;
  logic [6:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] alu_a, alu_b;
  logic [1:0]  alu_op;
  logic [15:0] alu_res;
  logic        alu_z;
  logic [6:0]  pc;
  logic        z_flag;
  logic [2:0]  state;

  logic [15:0] mem [128];
  logic        ld_en = 1'b0;
  logic [6:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;

  logic [15:0] ref_mem [128];
  logic [6:0]  ref_pc = '0;
  logic        ref_z = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  control_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_in_out (alu_res),
    .alu_in_z   (alu_z),
    .pc         (pc),
    .z_flag     (z_flag),
    .state      (state)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr] <= mem_wdata;
    else if (ld_en) mem[ld_addr]  <= ld_data;
  end

  always_comb begin
    alu_res = '0;
    case (alu_op)
      2'd0:    alu_res = alu_a + alu_b;
      2'd1:    alu_res = alu_a ^ alu_b;
      2'd2:    alu_res = alu_b;
      default: alu_res = '0;
    endcase
    alu_z = (alu_res == 16'd0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All tasks below start and end on a falling clock edge.
  task automatic load(input logic [6:0] a, input logic [15:0] d);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_z", 32'(z_flag), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_aluop", 32'(alu_op), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_ab", {alu_a, alu_b}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ref_pc = '0;
    ref_z = 1'b0;
  endtask

  // Architectural effect of one instruction plus its cycle cost and write count.
  task automatic model_step(output int exp_cyc, output int exp_we, output logic [6:0] d);
    logic [15:0] ins;
    logic [6:0]  s;
    logic [15:0] sum;
    ins = ref_mem[ref_pc];
    s = ins[13:7];
    d = ins[6:0];
    ref_pc = ref_pc + 7'd1;
    case (ins[15:14])
      2'b00: begin
        sum = ref_mem[d] + ref_mem[s];
        ref_mem[d] = sum;
        ref_z = (sum == 16'd0);
        exp_cyc = 5; exp_we = 1;
      end
      2'b01: begin
        ref_z = (ref_mem[d] == ref_mem[s]);
        exp_cyc = 5; exp_we = 0;
      end
      2'b10: begin
        ref_mem[d] = ref_mem[s];
        exp_cyc = 4; exp_we = 1;
      end
      default: begin
        if (ref_z) ref_pc = d;
        exp_cyc = 2; exp_we = 0;
      end
    endcase
  endtask

  task automatic run_instr(input string tag);
    int exp_cyc, exp_we, cyc, we;
    logic [6:0] d;
    bit done;
    model_step(exp_cyc, exp_we, d);
    en = 1'b1;
    cyc = 0; we = 0; done = 1'b0;
    while (!done && cyc < 12) begin
      if (mem_we) we++;
      @(posedge clk);
      cyc++;
      #1;
      if (state == 3'd0) done = 1'b1;
      @(negedge clk);
    end
    en = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_cycles"}, cyc, exp_cyc);
    chk({tag, "_writes"}, we, exp_we);
    chk({tag, "_pc"}, 32'(pc), 32'(ref_pc));
    chk({tag, "_z"}, 32'(z_flag), 32'(ref_z));
    chk({tag, "_dst"}, 32'(mem[d]), 32'(ref_mem[d]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, ew, ec;
    logic [6:0] d;
    @(negedge clk);
    for (int i = 0; i < 128; i++) load(7'(i), 16'd0);
    do_reset();

    // en low: no fetch, PC frozen
    repeat (3) @(negedge clk);
    chk("idle_pc", 32'(pc), 32'd0);
    chk("idle_state", 32'(state), 32'd0);

    load(7'd0, 16'h0105); load(7'd2, 16'h0003); load(7'd5, 16'h0004);
    run_instr("add");
    chk("add_val", 32'(mem[5]), 32'h7);

    do_reset();
    load(7'd0, 16'h4105); load(7'd2, 16'h1234); load(7'd5, 16'h1234); load(7'd1, 16'hC00A);
    run_instr("cmp");
    chk("cmp_z", 32'(z_flag), 32'd1);
    run_instr("beq");
    chk("beq_pc", 32'(pc), 32'd10);

    // MOV at PC 10 with Z=1: flag must survive
    load(7'd10, 16'h8185); load(7'd3, 16'hFFFF);
    run_instr("mov");
    chk("mov_val", 32'(mem[5]), 32'hFFFF);

    do_reset();
    load(7'd0, 16'h0105); load(7'd2, 16'h8000); load(7'd5, 16'h8000);
    run_instr("ovf");
    chk("ovf_z", 32'(z_flag), 32'd1);

    do_reset();
    load(7'd0, 16'h4000); load(7'd1, 16'hC07F); load(7'd127, 16'h8185);
    run_instr("wcmp");
    run_instr("wbeq");
    chk("wrap_at127", 32'(pc), 32'd127);
    run_instr("wmov");
    chk("wrap_pc0", 32'(pc), 32'd0);

    load(7'd0, 16'hC000);
    run_instr("halt1");
    run_instr("halt2");

    // Reset in EXEC of an ADD
    do_reset();
    load(7'd0, 16'h0105); load(7'd2, 16'h0003); load(7'd5, 16'h0004);
    en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("exec_state", 32'(state), 32'd4);
    chk("exec_we", 32'(mem_we), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rexec_we", 32'(mem_we), 32'd0);
    chk("rexec_state", 32'(state), 32'd0);
    chk("rexec_pc", 32'(pc), 32'd0);
    chk("rexec_addr", 32'(mem_addr), 32'd0);
    chk("rexec_aluop", 32'(alu_op), 32'd0);
    chk("rexec_ab", {alu_a, alu_b}, 32'd0);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("rexec_dst", 32'(mem[5]), 32'(ref_mem[5]));
    @(negedge clk);
    reset_n = 1'b1;
    ref_pc = '0;
    ref_z = 1'b0;

    // en dropped right after fetch: instruction completes, then holds
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    cyc = 1;
    while (state != 3'd0 && cyc < 12) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    model_step(ec, ew, d);
    chk("endrop_cycles", cyc, ec);
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("endrop_pc", 32'(pc), 32'(ref_pc));
    chk("endrop_state", 32'(state), 32'd0);
    chk("endrop_dst", 32'(mem[d]), 32'(ref_mem[d]));

    // Random program over the whole memory
    do_reset();
    for (int i = 0; i < 128; i++) load(7'(i), 16'($urandom()));
    for (int i = 0; i < 60; i++) run_instr("rnd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have reset_n, input, 1, reset that is asynchronous and active-low.
REQ-003 SHALL have en, input, 1, run enable; sampled only in FETCH.
REQ-004 SHALL have mem_rdata, input, 16, data word from asynchronous-read RAM at mem_addr, valid in the same cycle.
REQ-005 SHALL have mem_addr, output, 7, RAM word address.
REQ-006 SHALL have mem_wdata, output, 16, RAM write data, equal to alu_in_out.
REQ-007 SHALL have mem_we, output, 1, RAM write strobe; the write occurs on the next rising clk.
REQ-008 SHALL have alu_a and alu_b, outputs, 16 each, ALU operands equal to internal registers RA and RB.
REQ-009 SHALL have alu_op, output, 2, ALU function: 0 = add, 1 = xor, 2 = pass B.
REQ-010 SHALL have alu_in_out (input, 16, ALU result) and alu_in_z (input, 1, result-is-zero).
REQ-011 SHALL have pc (output, 7), z_flag (output, 1) and state (output, 3), all for debug and observation.

Function
REQ-012 Instruction format SHALL be [15:14] opcode, [13:7] src address, [6:0] dst address.
REQ-013 Opcodes SHALL be 00 ADD (dst = dst + src), 01 CMP (Z from dst xor src), 10 MOV (dst = src) and 11 BEQ (if Z then PC = dst).
REQ-014 State encodings SHALL be FETCH = 0, DECODE = 1, RD_SRC = 2, RD_DST = 3 and EXEC = 4; the values 5-7 SHALL go to FETCH on the next clk.
REQ-015 FETCH, en = 1: mem_addr = PC, IR <= mem_rdata, PC <= PC + 1 (mod 128), next state DECODE.
REQ-016 FETCH, en = 0: remain in FETCH, with no register change.
REQ-017 DECODE, BEQ: if z_flag = 1 then PC <= IR[6:0]; next state FETCH in either case.
REQ-018 DECODE, any other opcode: next state RD_SRC.
REQ-019 RD_SRC: mem_addr = IR[13:7], RB <= mem_rdata; next state is EXEC for MOV and RD_DST for ADD and CMP.
REQ-020 RD_DST: mem_addr = IR[6:0], RA <= mem_rdata; next state EXEC.
REQ-021 EXEC: mem_addr = IR[6:0] and alu_op per REQ-009 (ADD 0, CMP 1, MOV 2); next state FETCH.
REQ-022 EXEC, ADD and MOV: mem_we = 1.
REQ-023 EXEC, CMP: mem_we = 0.
REQ-024 EXEC, ADD and CMP: z_flag <= alu_in_z.
REQ-025 EXEC, MOV: z_flag SHALL be unchanged.
REQ-026 mem_we SHALL be a combinational decode of state and opcode, asserted only in EXEC and for exactly one cycle per ADD or MOV.
REQ-027 Outside EXEC, alu_op SHALL be 0.
REQ-028 Outside RD_SRC, RD_DST and EXEC, mem_addr SHALL be PC.
REQ-029 Latency SHALL be 5 cycles for ADD and CMP, 4 for MOV and 2 for BEQ, counted FETCH to the next FETCH.
REQ-030 Add SHALL be modulo 2^16 with no carry output.
REQ-031 PC SHALL wrap from 127 to 0 without error.
REQ-032 When src equals dst, both reads SHALL occur normally: ADD doubles the word and CMP sets Z = 1.
REQ-033 A BEQ taken to the current PC SHALL loop indefinitely; this is legal and is the halt idiom.
REQ-034 Deasserting en mid-instruction SHALL complete the instruction and stop at the next FETCH.

Reset
REQ-035 reset_n = 0 SHALL immediately force state = FETCH, PC = 0, IR = 0, RA = 0, RB = 0, z_flag = 0, mem_we = 0, alu_op = 0 and mem_addr = 0, regardless of clk.
REQ-036 Reset asserted during EXEC SHALL drop mem_we in the same cycle, so no partial write occurs.
REQ-037 After reset_n rises, the first FETCH SHALL occur on the first rising clk with en = 1.

Verification
REQ-038 Scenario ADD: mem[0] = 0x0105 (ADD src 2, dst 5), mem[2] = 0x0003, mem[5] = 0x0004 -> after 5 cycles mem[5] = 0x0007, z_flag = 0, PC = 1.
REQ-039 Scenario CMP then BEQ: mem[0] = 0x4105 with mem[2] = mem[5] = 0x1234, and mem[1] = 0xC00A -> z_flag = 1 after 5 cycles, and PC = 10 at cycle 7.
REQ-040 Scenario MOV: mem[0] = 0x8185 (src 3, dst 5) with mem[3] = 0xFFFF -> after 4 cycles mem[5] = 0xFFFF, z_flag unchanged, and mem_we high for exactly 1 cycle.
REQ-041 Scenario ADD overflow: ADD of 0x8000 + 0x8000 -> dst = 0x0000 and z_flag = 1.
REQ-042 Scenario wrap: PC = 127 executing MOV -> next fetch from address 0.
REQ-043 Scenario reset and en: reset_n pulsed low in EXEC of an ADD -> mem_we falls the same cycle, dst unchanged, and all outputs at reset values; en = 0 holds FETCH with PC frozen.
